// File: rtl/key_expansion.sv
// -----------------------------------------------------------------------------
// key_expansion
//   AES-128 on-the-fly key schedule. A start request captures a 128-bit cipher
//   key and the block then streams the 11 round keys (round 0 = cipher key,
//   rounds 1..10 derived) over a valid/ready handshake. A new round key is
//   computed only when the current one is accepted, so one 128-bit register
//   holds the whole schedule state.
//
// Ports
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    load key_in and begin a schedule (ignored while busy)
//   key_in     in   128  cipher key, byte 0 at [127:120], w0 at [127:96]
//   rk_ready   in   1    downstream accepts round_key this cycle
//   round_key  out  128  current round key, same byte order as key_in
//   round_num  out  4    index of round_key, 0..10
//   rk_valid   out  1    round_key / round_num valid
//   busy       out  1    schedule in progress
//   done       out  1    one-cycle pulse after round 10 is accepted
// -----------------------------------------------------------------------------

// Byte substitution: FIPS-197 S-box as a combinational lookup table.
module key_expansion_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    // Ascending packed range: element 0 sits in the most significant byte of
    // the literal, so the table reads in natural S-box order.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX[in_i];
endmodule

module key_expansion (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         rk_valid,
    output logic         busy,
    output logic         done
);
    localparam int         NUM_BYTES  = 4;
    localparam logic [3:0] LAST_ROUND = 4'd10;
    localparam logic [7:0] RCON_INIT  = 8'h01;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]   state_q,     state_d;
    logic [127:0] round_key_q, round_key_d;
    logic [3:0]   round_num_q, round_num_d;
    logic [7:0]   rcon_q,      rcon_d;
    logic         rk_valid_q,  rk_valid_d;
    logic         busy_q,      busy_d;
    logic         done_q,      done_d;

    // ---------------------------------------------------------------------
    // Next round key datapath
    // ---------------------------------------------------------------------
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w3;
    logic [31:0] sub_w3;
    logic [31:0] temp;
    logic [31:0] nw0, nw1, nw2, nw3;
    logic [127:0] next_key;
    logic [7:0]   next_rcon;

    assign {w0, w1, w2, w3} = round_key_q;

    // RotWord: {a,b,c,d} -> {b,c,d,a}
    assign rot_w3 = {w3[23:0], w3[31:24]};

    // SubWord: one S-box per byte of the rotated word
    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_sub
        key_expansion_sbox u_sbox (
            .in_i  (rot_w3[8*g +: 8]),
            .out_o (sub_w3[8*g +: 8])
        );
    end

    assign temp     = sub_w3 ^ {rcon_q, 24'h0};
    assign nw0      = w0 ^ temp;
    assign nw1      = w1 ^ nw0;
    assign nw2      = w2 ^ nw1;
    assign nw3      = w3 ^ nw2;
    assign next_key = {nw0, nw1, nw2, nw3};

    // xtime in GF(2^8): 01,02,...,80,1b,36
    assign next_rcon = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    // ---------------------------------------------------------------------
    // Control
    // ---------------------------------------------------------------------
    logic handshake;
    assign handshake = rk_valid_q & rk_ready;

    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        round_num_d = round_num_q;
        rcon_d      = rcon_q;
        rk_valid_d  = rk_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // done is high in the first IDLE cycle, so a start here is
                // taken and back-to-back schedules lose no cycle.
                if (start) begin
                    round_key_d = key_in;
                    round_num_d = 4'd0;
                    rcon_d      = RCON_INIT;
                    rk_valid_d  = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                // start is deliberately not looked at while a schedule runs.
                if (handshake) begin
                    if (round_num_q == LAST_ROUND) begin
                        // round_key keeps the round-10 value after completion
                        rk_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        round_key_d = next_key;
                        round_num_d = round_num_q + 4'd1;
                        rcon_d      = next_rcon;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                rk_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            round_key_q <= '0;
            round_num_q <= '0;
            rcon_q      <= RCON_INIT;
            rk_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_num_q <= round_num_d;
            rcon_q      <= rcon_d;
            rk_valid_q  <= rk_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign round_key = round_key_q;
    assign round_num = round_num_q;
    assign rk_valid  = rk_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_key_expansion.sv
// -----------------------------------------------------------------------------
// tb_key_expansion
//   Self-checking bench for key_expansion. The reference builds the S-box from
//   GF(2^8) inversion plus the affine map and expands keys with the FIPS-197
//   word loop (w[0..43]), independent of the DUT's table and datapath.
// -----------------------------------------------------------------------------
module tb_key_expansion;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         rk_valid;
    logic         busy;
    logic         done;

    key_expansion dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .round_num (round_num),
        .rk_valid  (rk_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]   sb     [256];
    logic [127:0] exp_rk [11];
    logic [127:0] got_rk [11];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_key(input int r, input string tag);
        chk($sformatf("%s_valid_r%0d", tag, r), 128'(rk_valid), 128'd1);
        chk($sformatf("%s_num_r%0d", tag, r), 128'(round_num), 128'(r));
        chk($sformatf("%s_key_r%0d", tag, r), round_key, exp_rk[r]);
        chk($sformatf("%s_done_r%0d", tag, r), 128'(done), 128'd0);
        got_rk[r] = round_key;
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"}, 128'(done), 128'd1);
        chk({tag, "_valid_after"}, 128'(rk_valid), 128'd0);
        chk({tag, "_busy_after"}, 128'(busy), 128'd0);
        chk({tag, "_key_held"}, round_key, exp_rk[10]);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_key"}, round_key, 128'd0);
        chk({tag, "_num"}, 128'(round_num), 128'd0);
        chk({tag, "_valid"}, 128'(rk_valid), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_done"}, 128'(done), 128'd0);
    endtask

    task automatic launch(input logic [127:0] k);
        expand(k);
        key_in = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // ready held high; key_in scrambled every cycle to show it is not re-sampled
    task automatic run_body(input string tag);
        rk_ready = 1'b1;
        for (int r = 0; r <= 10; r++) begin
            check_key(r, tag);
            key_in = rnd128();
            tick();
        end
        check_done(tag);
    endtask

    initial begin
        logic [127:0] k;
        int idx, cyc;
        bit rdy;

        build_sbox();
        rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = '0;
        #12;
        check_idle("reset");

        // ready with nothing valid has no effect
        @(negedge clk);
        rst_n = 1'b1;
        rk_ready = 1'b1;
        tick(); tick();
        check_idle("ready_no_valid");

        // FIPS-197 A.1 vector, full-rate
        launch(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_body("fips");
        chk("fips_const_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_const_r2", got_rk[2], 128'hf2c295f27a96b9435935807a7359f67f);
        chk("fips_const_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // start in the done cycle: accepted, round 0 valid next cycle
        expand(128'h0);
        key_in = 128'h0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        run_body("zero_b2b");
        chk("zero_const_r1", got_rk[1], 128'h62636363626363636263636362636363);
        chk("zero_const_r10", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        tick();
        chk("done_one_cycle", 128'(done), 128'd0);
        chk("idle_valid", 128'(rk_valid), 128'd0);

        // random keys with random backpressure and stray starts during busy
        for (int run = 0; run < 4; run++) begin
            k = rnd128();
            launch(k);
            idx = 0; cyc = 0;
            while (idx <= 10 && cyc < 400) begin
                check_key(idx, $sformatf("bp%0d", run));
                rdy      = 1'($urandom_range(0, 1));
                rk_ready = rdy;
                start    = ($urandom_range(0, 5) == 0);
                key_in   = rnd128();
                tick();
                if (rdy) idx++;
                cyc++;
            end
            start = 1'b0;
            if (cyc >= 400) chk("bp_timeout", 128'(cyc), 128'd0);
            check_done($sformatf("bp%0d", run));
            rk_ready = 1'($urandom_range(0, 1));
            tick();
            chk($sformatf("bp%0d_done_once", run), 128'(done), 128'd0);
            chk($sformatf("bp%0d_stays_idle", run), 128'(rk_valid), 128'd0);
        end

        // start with a different key at round 5 is ignored
        k = rnd128();
        launch(k);
        rk_ready = 1'b1;
        for (int r = 0; r <= 10; r++) begin
            check_key(r, "mid_start");
            start  = (r == 5);
            key_in = ~k;
            tick();
        end
        start = 1'b0;
        check_done("mid_start");
        tick();

        // reset at round 4 aborts; no done; next start runs cleanly
        k = rnd128();
        launch(k);
        rk_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            check_key(r, "pre_rst");
            tick();
        end
        check_key(4, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        tick(); tick();
        check_idle("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle("after_rst_no_start");
        // start presented before the first edge after release
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        k = rnd128();
        launch(k);
        run_body("post_rst");
        tick();
        chk("post_rst_done_once", 128'(done), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // hard stop so the bench can never hang
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
